// File: rtl/uart_rx_fsm.sv
// 8-bit UART receiver: 1 start, 8 data (LSB first), 1 parity, 1 stop bit.
// Oversampled by baud_tick with a mid-bit sampling point.
module uart_rx_fsm #(
  parameter int OVERSAMPLE = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       baud_tick,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t          state;
  logic [TW-1:0]   tick_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift_reg;
  logic            perr;
  logic            rx_m;
  logic            rx_s;

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      perr       <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (baud_tick) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state    <= START;
              tick_cnt <= '0;
              rx_busy  <= 1'b1;
            end
          end
          // A start bit that is gone by mid-bit is treated as a glitch.
          START: begin
            if (tick_cnt == TICK_MID) begin
              tick_cnt <= '0;
              if (rx_s) begin
                state   <= IDLE;
                rx_busy <= 1'b0;
              end else begin
                state   <= DATA;
                bit_cnt <= '0;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          DATA: begin
            if (tick_cnt == TICK_END) begin
              shift_reg <= {rx_s, shift_reg[7:1]};
              tick_cnt  <= '0;
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state <= PARITY;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          PARITY: begin
            if (tick_cnt == TICK_END) begin
              perr     <= rx_s ^ (^shift_reg) ^ PARITY_ODD;
              tick_cnt <= '0;
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          // Leaving at mid stop bit leaves room for a back-to-back start edge.
          STOP: begin
            if (tick_cnt == TICK_END) begin
              rx_data    <= shift_reg;
              parity_err <= perr;
              frame_err  <= ~rx_s;
              rx_valid   <= 1'b1;
              tick_cnt   <= '0;
              state      <= IDLE;
              rx_busy    <= 1'b0;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          default: begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            rx_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
